// File: rtl/conv_pkg.sv
// Shared types, defaults and the rescale/saturate helper for the 3x3 streaming convolution.
package conv_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_FRAC   = 8;
  localparam int SAT_W          = 64;

  typedef logic signed [DEFAULT_DATA_W-1:0]   pix_t;
  typedef logic signed [2*DEFAULT_DATA_W+3:0] acc_t;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Arithmetic shift by frac, then clamp to the signed data_w range.
  // The caller keeps the low data_w bits of the returned value.
  function automatic logic signed [SAT_W-1:0] sat_shift(
    input logic signed [SAT_W-1:0] acc,
    input int                      frac,
    input int                      data_w
  );
    logic signed [SAT_W-1:0] res;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] out;
    res = acc >>> frac;
    hi  = (SAT_W'(1) <<< (data_w - 1)) - SAT_W'(1);
    lo  = -hi - SAT_W'(1);
    out = res;
    if (res > hi) out = hi;
    if (res < lo) out = lo;
    return out;
  endfunction

endpackage

// File: rtl/conv3x3_line_buf.sv
// Two-row line buffer plus 3x3 window register; tracks raster position and
// flags which beats complete a valid window.
module conv3x3_line_buf
  import conv_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                clk,
  input  logic                RESET,
  input  logic                en,
  input  logic [DATA_W-1:0]   pix,
  output logic [9*DATA_W-1:0] win,
  output logic                first_pix,
  output logic                win_valid,
  output logic                win_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] win_q [9];
  logic [DATA_W-1:0] win_d [9];
  logic [DATA_W-1:0] line0_mem [IMG_W];
  logic [DATA_W-1:0] line1_mem [IMG_W];
  logic              at_row_end;
  logic              at_frame_end;

  assign at_row_end   = (col_q == CW'(IMG_W - 1));
  assign at_frame_end = at_row_end && (row_q == RW'(IMG_H - 1));
  assign first_pix    = (col_q == '0) && (row_q == '0);

  // Window index 3*r+c: r=0 is the oldest row, c=0 the oldest column.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    win_d   = win_q;
    if (en) begin
      valid_d = (row_q >= RW'(2)) && (col_q >= CW'(2));
      last_d  = at_frame_end;
      col_d   = at_row_end ? '0 : col_q + CW'(1);
      if (at_row_end) row_d = at_frame_end ? '0 : row_q + RW'(1);
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]   = win_q[3*r+1];
        win_d[3*r+1] = win_q[3*r+2];
      end
      win_d[2] = line1_mem[col_q];
      win_d[5] = line0_mem[col_q];
      win_d[8] = pix;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    win_q <= win_d;
    if (en) begin
      line0_mem[col_q] <= pix;
      line1_mem[col_q] <= line0_mem[col_q];
    end
  end

  for (genvar gi = 0; gi < 9; gi++) begin : g_win
    assign win[gi*DATA_W +: DATA_W] = win_q[gi];
  end

  assign win_valid = valid_q;
  assign win_last  = last_q;

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 valid-mode convolution, N_OUT kernels in parallel, with weight
// loading, fixed-point rescale, saturation and optional ReLU.
module conv3x3_stream
  import conv_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int N_OUT  = 3,
  parameter int FRAC   = DEFAULT_FRAC,
  parameter int ACC_W  = 2*DATA_W + 4
) (
  input  logic                    clk,
  input  logic                    RESET,
  input  logic                    relu_en,
  input  logic                    w_valid,
  input  logic [DATA_W-1:0]       w_data,
  output logic                    w_ready,
  input  logic                    pix_valid,
  input  logic [DATA_W-1:0]       pix_data,
  output logic                    pix_ready,
  output logic                    out_valid,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic                    frame_done
);

  localparam int CHW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int PW  = 2*DATA_W;

  state_t                   state_q, state_d;
  logic [3:0]               wk_q, wk_d;
  logic [CHW-1:0]           wch_q, wch_d;
  logic signed [DATA_W-1:0] wgt_q  [N_OUT][9];
  logic signed [DATA_W-1:0] wgt_d  [N_OUT][9];
  logic signed [DATA_W-1:0] bias_q [N_OUT];
  logic signed [DATA_W-1:0] bias_d [N_OUT];

  logic                     beat;
  logic [9*DATA_W-1:0]      win_flat;
  logic signed [DATA_W-1:0] win_w [9];
  logic                     first_pix, win_valid, win_last;

  logic relu_now;
  logic relu_q, relu_d, relu_s1_q, relu_s1_d, relu_s2_q, relu_s2_d;
  logic v2_q, v2_d, last2_q, last2_d;
  logic out_valid_q, out_valid_d, frame_done_q, frame_done_d;
  logic [N_OUT*DATA_W-1:0] out_data_q, out_data_d, res_all;

  assign w_ready   = (state_q == LOAD);
  assign pix_ready = (state_q == RUN);
  assign beat      = pix_valid && pix_ready;

  conv3x3_line_buf #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H)
  ) u_line_buf (
    .clk       (clk),
    .RESET     (RESET),
    .en        (beat),
    .pix       (pix_data),
    .win       (win_flat),
    .first_pix (first_pix),
    .win_valid (win_valid),
    .win_last  (win_last)
  );

  always_comb begin
    state_d = state_q;
    wk_d    = wk_q;
    wch_d   = wch_q;
    wgt_d   = wgt_q;
    bias_d  = bias_q;
    if (w_valid && w_ready) begin
      if (wk_q == 4'd9) begin
        bias_d[wch_q] = w_data;
        wk_d          = '0;
        if (wch_q == CHW'(N_OUT - 1)) begin
          wch_d   = '0;
          state_d = RUN;
        end else begin
          wch_d = wch_q + CHW'(1);
        end
      end else begin
        wgt_d[wch_q][wk_q] = w_data;
        wk_d               = wk_q + 4'd1;
      end
    end

    // ReLU mode travels with each window so back-to-back frames with
    // different modes do not mix in the pipeline.
    relu_now     = first_pix ? relu_en : relu_q;
    relu_d       = beat ? relu_now : relu_q;
    relu_s1_d    = beat ? relu_now : relu_s1_q;
    relu_s2_d    = relu_s1_q;
    v2_d         = win_valid;
    last2_d      = win_last;
    out_valid_d  = v2_q;
    frame_done_d = last2_q;
    out_data_d   = v2_q ? res_all : out_data_q;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q      <= LOAD;
      wk_q         <= '0;
      wch_q        <= '0;
      relu_q       <= 1'b0;
      relu_s1_q    <= 1'b0;
      relu_s2_q    <= 1'b0;
      v2_q         <= 1'b0;
      last2_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      wk_q         <= wk_d;
      wch_q        <= wch_d;
      relu_q       <= relu_d;
      relu_s1_q    <= relu_s1_d;
      relu_s2_q    <= relu_s2_d;
      v2_q         <= v2_d;
      last2_q      <= last2_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      out_data_q   <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    wgt_q  <= wgt_d;
    bias_q <= bias_d;
  end

  for (genvar gi = 0; gi < 9; gi++) begin : g_win
    assign win_w[gi] = win_flat[gi*DATA_W +: DATA_W];
  end

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_ch
    logic signed [PW-1:0]     prod_q [9];
    logic signed [PW-1:0]     prod_d [9];
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] res;

    always_comb begin
      for (int i = 0; i < 9; i++) begin
        prod_d[i] = PW'(win_w[i]) * PW'(wgt_q[gi][i]);
      end
    end

    always_ff @(posedge clk) begin
      prod_q <= prod_d;
    end

    always_comb begin
      acc = ACC_W'(bias_q[gi]) <<< FRAC;
      for (int i = 0; i < 9; i++) begin
        acc = acc + ACC_W'(prod_q[i]);
      end
      res = DATA_W'(sat_shift(SAT_W'(acc), FRAC, DATA_W));
      if (relu_s2_q && res[DATA_W-1]) res = '0;
    end

    assign res_all[gi*DATA_W +: DATA_W] = res;
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign out_data   = out_data_q;

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed and randomized checks of conv3x3_stream against a direct
// arithmetic model of valid-mode 3x3 convolution on a 5x5 image.
module tb_conv3x3_stream;

  localparam int DW = 16;
  localparam int W  = 5;
  localparam int H  = 5;
  localparam int NO = 3;
  localparam int FR = 8;

  logic              clk = 1'b0;
  logic              RESET;
  logic              relu_en;
  logic              w_valid;
  logic [DW-1:0]     w_data;
  logic              w_ready;
  logic              pix_valid;
  logic [DW-1:0]     pix_data;
  logic              pix_ready;
  logic              out_valid;
  logic [NO*DW-1:0]  out_data;
  logic              frame_done;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int out_idx     = 0;

  int wt  [NO][10];   // 0..8 = w0..w8 row-major, 9 = bias
  int img [H][W];
  bit model_relu;

  typedef struct {
    logic [NO*DW-1:0] vec;
    bit               last;
    int               t;
  } exp_t;
  exp_t expq[$];

  conv3x3_stream #(
    .DATA_W (DW),
    .IMG_W  (W),
    .IMG_H  (H),
    .N_OUT  (NO),
    .FRAC   (FR)
  ) dut (
    .clk        (clk),
    .RESET      (RESET),
    .relu_en    (relu_en),
    .w_valid    (w_valid),
    .w_data     (w_data),
    .w_ready    (w_ready),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output pixel whose window's bottom-right input sits at image (r, c).
  function automatic longint ref_pixel(input int k, input int r, input int c);
    longint acc;
    longint hi;
    hi  = (longint'(1) << (DW - 1)) - 1;
    acc = longint'(wt[k][9]) * (longint'(1) << FR);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        acc += longint'(wt[k][i*3+j]) * longint'(img[r-2+i][c-2+j]);
    acc = acc >>> FR;
    if (acc > hi) acc = hi;
    if (acc < -hi - 1) acc = -hi - 1;
    if (model_relu && acc < 0) acc = 0;
    return acc;
  endfunction

  task automatic monitor();
    exp_t e;
    if (out_valid === 1'b1) begin
      if (expq.size() == 0) begin
        chk("spurious_out_valid", out_valid, 0);
      end else begin
        e = expq.pop_front();
        for (int k = 0; k < NO; k++)
          chk($sformatf("out%0d_ch%0d", out_idx, k),
              $signed(out_data[k*DW +: DW]), $signed(e.vec[k*DW +: DW]));
        chk($sformatf("out%0d_frame_done", out_idx), frame_done, e.last);
        chk($sformatf("out%0d_cycle", out_idx), cyc, e.t);
        out_idx++;
      end
    end else begin
      chk("frame_done_idle", frame_done, 0);
    end
  endtask

  task automatic clk_cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int r, input int c);
    exp_t e;
    logic [NO*DW-1:0] v;
    v = '0;
    for (int k = 0; k < NO; k++) v[k*DW +: DW] = DW'(ref_pixel(k, r, c));
    e.vec  = v;
    e.last = (r == H-1) && (c == W-1);
    e.t    = cyc + 3;   // three register stages after the presenting cycle
    expq.push_back(e);
  endtask

  task automatic send_frame(input bit gapped, input int n_pix);
    for (int n = 0; n < n_pix; n++) begin
      if (gapped && (n % 2 == 1)) begin
        pix_valid = 1'b0;
        pix_data  = 16'hDEAD;
        clk_cycle();
      end
      pix_valid = 1'b1;
      pix_data  = DW'(img[n / W][n % W]);
      chk("pix_ready_run", pix_ready, 1);
      if ((n / W) >= 2 && (n % W) >= 2) push_exp(n / W, n % W);
      clk_cycle();
    end
    pix_valid = 1'b0;
  endtask

  task automatic drain();
    pix_valid = 1'b0;
    for (int i = 0; i < 20 && expq.size() > 0; i++) clk_cycle();
    chk("drain_pending", expq.size(), 0);
  endtask

  // Pixels offered throughout loading must never be consumed.
  task automatic load_weights();
    pix_valid = 1'b1;
    pix_data  = 16'h5A5A;
    for (int k = 0; k < NO; k++)
      for (int i = 0; i < 10; i++) begin
        w_valid = 1'b1;
        w_data  = DW'(wt[k][i]);
        chk("w_ready_load", w_ready, 1);
        chk("pix_ready_load", pix_ready, 0);
        clk_cycle();
      end
    w_valid   = 1'b0;
    pix_valid = 1'b0;
    chk("w_ready_after_last", w_ready, 0);
    chk("pix_ready_after_last", pix_ready, 1);
  endtask

  task automatic do_reset();
    RESET     = 1'b1;
    w_valid   = 1'b0;
    pix_valid = 1'b1;
    pix_data  = 16'h1234;
    clk_cycle();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_w_ready", w_ready, 1);
    chk("rst_pix_ready", pix_ready, 0);
    clk_cycle();
    RESET = 1'b0;
  endtask

  task automatic set_scenario1();
    for (int k = 0; k < NO; k++)
      for (int i = 0; i < 10; i++) wt[k][i] = 0;
    for (int i = 0; i < 9; i++) wt[0][i] = 256;
    wt[1][4] = 256;
    wt[1][9] = 2;
    wt[2][9] = -3;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = r*W + c + 1;
  endtask

  task automatic set_uniform(input int w, input int p);
    for (int k = 0; k < NO; k++) begin
      for (int i = 0; i < 9; i++) wt[k][i] = w;
      wt[k][9] = 0;
    end
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = p;
  endtask

  initial begin
    RESET      = 1'b1;
    relu_en    = 1'b0;
    model_relu = 1'b0;
    w_valid    = 1'b0;
    w_data     = '0;
    pix_valid  = 1'b0;
    pix_data   = '0;

    // Reset state, load with pixels pending, first frame with weights pending.
    do_reset();
    set_scenario1();
    load_weights();
    w_valid = 1'b1;
    w_data  = 16'h7FFF;
    send_frame(1'b0, W*H);
    chk("w_ready_run", w_ready, 0);
    drain();
    w_valid = 1'b0;

    // Two frames back to back, then a gapped frame.
    send_frame(1'b0, W*H);
    send_frame(1'b0, W*H);
    drain();
    send_frame(1'b1, W*H);
    drain();

    // Reset after pixel 15: outputs still in flight are discarded.
    send_frame(1'b0, 15);
    RESET = 1'b1;
    while (expq.size() > 0 && expq[$].t > cyc) void'(expq.pop_back());
    clk_cycle();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_w_ready", w_ready, 1);
    chk("midrst_pix_ready", pix_ready, 0);
    chk("midrst_pending", expq.size(), 0);
    clk_cycle();
    RESET = 1'b0;
    load_weights();
    send_frame(1'b0, W*H);
    drain();

    // Positive and negative saturation, then ReLU on the negative case.
    do_reset();
    set_uniform(32767, 32767);
    load_weights();
    send_frame(1'b0, W*H);
    drain();
    do_reset();
    set_uniform(-32768, 32767);
    load_weights();
    send_frame(1'b0, W*H);
    drain();
    relu_en    = 1'b1;
    model_relu = 1'b1;
    send_frame(1'b0, W*H);
    drain();

    // Randomized weights, biases, pixels and ReLU mode.
    for (int t = 0; t < 3; t++) begin
      do_reset();
      for (int k = 0; k < NO; k++)
        for (int i = 0; i < 10; i++) wt[k][i] = int'($urandom_range(0, 1023)) - 512;
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(0, 4000)) - 2000;
      model_relu = 1'($urandom_range(0, 1));
      relu_en    = model_relu;
      load_weights();
      send_frame(1'($urandom_range(0, 1)), W*H);
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conv3x3_stream.md
Name: conv3x3_stream

Overview:
- Streaming 3x3 valid-mode convolution over a raster-scan single-channel image; produces N_OUT output feature channels in parallel, one output pixel per accepted input pixel once the window is full.
- Parametrised successor of the fixed 16-bit/3-channel conv stage:
  - generic width, image size and channel count;
  - weights and biases loaded through a handshake stream;
  - fixed-point rescale with saturation and optional ReLU.
- Sits between the pixel source and the pooling/next-layer stage.

Parameters:
- DATA_W, 16, signed pixel/weight/bias/output width.
- IMG_W, 28, pixels per row; must be at least 3.
- IMG_H, 28, rows per frame; must be at least 3.
- N_OUT, 3, output channels (kernels).
- FRAC, 8, fractional bits of weights; accumulator is arithmetic-shifted right by FRAC.
- ACC_W, 2*DATA_W+4, accumulator width (holds 9 products plus bias without overflow).

Ports:
- clk  in  1  clock; all state changes on posedge.
- RESET  in  1  synchronous, active-high reset.
- relu_en  in  1  1 = clamp negative outputs to 0; sampled at frame start.
- w_valid  in  1  weight/bias word valid.
- w_data  in  DATA_W  weight or bias word, signed.
- w_ready  out  1  high in LOAD state only.
- pix_valid  in  1  input pixel valid.
- pix_data  in  DATA_W  input pixel, signed.
- pix_ready  out  1  high in RUN state only.
- out_valid  out  1  one-cycle strobe, all channels valid together.
- out_data  out  N_OUT*DATA_W  channel k in bits [k*DATA_W +: DATA_W].
- frame_done  out  1  one-cycle pulse with the last output of a frame.

Behaviour:
- Reset values:
  - state=LOAD; w_ready=1; pix_ready=0; out_valid=0; out_data=0; frame_done=0.
  - All counters 0. Line buffers and weights are not cleared.
- FSM has two states, LOAD and RUN.
- LOAD:
  - Accepts N_OUT*10 words on w_valid&w_ready.
  - Word order per channel k: w0..w8 (row-major, w0 = top-left, i.e. oldest row and oldest column), then bias_k.
  - After the last word is accepted: go to RUN; w_ready=0 from the next cycle.
- RUN:
  - pix_ready=1. Each pix_valid&pix_ready beat advances the column counter and the 2-row line buffer (depth IMG_W each) and shifts the 3x3 window.
  - Gaps in pix_valid freeze the whole pipeline front; no state changes without a beat.
  - Window valid when row>=2 and col>=2. Output grid is (IMG_W-2)x(IMG_H-2).
  - Column wrap at IMG_W-1 -> col=0, row+1.
  - At row=IMG_H-1, col=IMG_W-1: assert frame_done with that output; counters go to 0; remain in RUN with the same weights; the next beat starts a new frame.
- Arithmetic per channel, all signed:
  - acc = sum of 9 full-width products + (bias << FRAC).
  - res = acc >>> FRAC.
  - Saturate res to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - If relu_en (latched), negative results become 0.
- Latency: fixed 3 cycles from the accepting beat to out_valid.
  - Stage 1: window register.
  - Stage 2: products.
  - Stage 3: sum, shift, saturate.
  - Pipeline advances every cycle after stage 1, so outputs from gapped inputs keep the same 3-cycle latency and spacing.
- Weight reload: asserting RESET returns to LOAD. There is no reload path without reset.
- RESET mid-frame:
  - Discards in-flight window/pipeline results; out_valid=0 the next cycle.
  - Counters cleared; the partial frame is lost.
- Simultaneous w_valid in RUN and pix_valid in LOAD are ignored (their ready is low).

Decomposition:
- Shared package conv_pkg:
  - default DATA_W/FRAC;
  - typedef for signed pixel and accumulator;
  - state enum {LOAD, RUN};
  - function sat_shift(acc) returning DATA_W saturated result.
- Sub-module conv3x3_line_buf (parameters DATA_W, IMG_W):
  - on each enable, shifts in the pixel;
  - presents the 3x3 window as 9 registered words;
  - owns the row/col counters and the window-valid flag.
- MAC/saturate lives in the top as a generate loop over N_OUT.

Test Plan:
- Load, N_OUT=3, FRAC=8, IMG_W=IMG_H=5:
  - ch0 all weights 256 (1.0), bias 0; ch1 centre 256, others 0, bias 2; ch2 all 0, bias -3; stream pixels 1..25 back-to-back.
  - Required: 9 outputs. First (at cycle 3 after pixel 13 is accepted): ch0=63, ch1=9, ch2=-3. Last: ch0=171, ch1=21. frame_done coincides with the 9th output.
- Saturation:
  - all weights 32767, pixels 32767, DATA_W=16.
  - ch0 = 32767. With all weights -32768, ch0 = -32768; with relu_en=1 it is 0.
- Gapped input: same stream as scenario 1 with pix_valid toggling 1/0.
  - Same 9 values in the same order; each out_valid exactly 3 cycles after its accepting beat.
- Handshake: drive pix_valid during LOAD and w_valid during RUN.
  - No pixels or weights consumed. w_ready drops exactly one cycle after the 30th weight.
- Back-to-back frames: two 5x5 frames with no gap.
  - Two identical 9-output sequences and two frame_done pulses; the second frame's first output is not polluted by frame-1 rows.
- RESET asserted after pixel 15 of a frame:
  - out_valid=0 the next cycle; w_ready=1. After reloading weights, a fresh frame reproduces scenario 1 exactly.
